// File: rtl/row_mac.sv
// row_mac: streaming sparse-row dot-product engine; pops matched vector and
// matrix FIFO heads, runs a two-stage multiply/accumulate pipeline and emits
// one result per row with valid/ready backpressure.
// Ports: clk, rst (async active-low); start/num_rows launch a block of rows;
// vec/vec_fifo_empty/vec_fifo_read and mat_val/mat_last/mat_fifo_empty/
// mat_fifo_read are the FWFT FIFO heads and pops; res/res_row/res_valid/
// res_ready deliver results; done pulses once per completed block.
module row_mac #(
    parameter int val_bits    = 16,
    parameter int acc_bits    = 40,
    parameter int row_id_size = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [row_id_size-1:0] num_rows,
    input  logic [val_bits-1:0]    vec,
    input  logic                   vec_fifo_empty,
    output logic                   vec_fifo_read,
    input  logic [val_bits-1:0]    mat_val,
    input  logic                   mat_last,
    input  logic                   mat_fifo_empty,
    output logic                   mat_fifo_read,
    output logic [acc_bits-1:0]    res,
    output logic [row_id_size-1:0] res_row,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [row_id_size-1:0] rows, rows_issued, row_cnt;
    logic s1_valid, s1_last, en, pop, accept;
    logic signed [2*val_bits-1:0] mul;
    logic signed [acc_bits-1:0] prod, acc, sum;
    // the whole pipeline freezes while a finished result waits for the consumer
    assign en = !(res_valid && !res_ready);
    assign pop = state == RUN && en && !vec_fifo_empty && !mat_fifo_empty && rows_issued < rows;
    assign vec_fifo_read = pop;
    assign mat_fifo_read = pop;
    assign mul = $signed(vec) * $signed(mat_val);
    assign sum = acc + prod;
    assign accept = res_valid && res_ready;
    assign done = state == DONE;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rows        <= '0;
            rows_issued <= '0;
            row_cnt     <= '0;
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            prod        <= '0;
            acc         <= '0;
            res         <= '0;
            res_row     <= '0;
            res_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    rows        <= num_rows;
                    rows_issued <= '0;
                    row_cnt     <= '0;
                    res_row     <= '0;
                    state       <= num_rows == '0 ? DONE : RUN;
                end
                RUN: if (accept && res_row == rows - row_id_size'(1)) state <= DONE;
                default: state <= IDLE;
            endcase
            if (pop && mat_last) rows_issued <= rows_issued + row_id_size'(1);
            if (en) begin
                s1_valid <= pop;
                if (pop) begin
                    prod    <= acc_bits'(mul);
                    s1_last <= mat_last;
                end
            end
            // a result loaded on the accepting edge keeps res_valid high
            if (accept) res_valid <= 1'b0;
            if (en && s1_valid) begin
                if (s1_last) begin
                    res       <= sum;
                    acc       <= '0;
                    res_valid <= 1'b1;
                    res_row   <= row_cnt;
                    row_cnt   <= row_cnt + row_id_size'(1);
                end else begin
                    acc <= sum;
                end
            end
        end
    end
endmodule

// File: tb/tb_row_mac.sv
// tb_row_mac: directed self-checking bench for row_mac with queue-based FIFO models.
module tb_row_mac;
    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, res_ready = 1'b1;
    logic [9:0]  num_rows = '0;
    logic [15:0] vec, mat_val;
    logic        vec_fifo_empty, mat_last, mat_fifo_empty;
    logic        vec_fifo_read, mat_fifo_read, res_valid, done;
    logic [39:0] res;
    logic [9:0]  res_row;
    logic [15:0] vq[$], mq[$];
    logic        lq[$];
    logic        vmask = 1'b0, vtog = 1'b0;
    int          checks = 0, failures = 0, pops = 0;
    logic        rd, s_valid, s_done;
    logic [39:0] s_res;
    logic [9:0]  s_row;

    row_mac dut (
        .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
        .vec(vec), .vec_fifo_empty(vec_fifo_empty), .vec_fifo_read(vec_fifo_read),
        .mat_val(mat_val), .mat_last(mat_last), .mat_fifo_empty(mat_fifo_empty),
        .mat_fifo_read(mat_fifo_read), .res(res), .res_row(res_row),
        .res_valid(res_valid), .res_ready(res_ready), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd;
        vec            = vq.size() != 0 ? vq[0] : '0;
        mat_val        = mq.size() != 0 ? mq[0] : '0;
        mat_last       = lq.size() != 0 ? lq[0] : 1'b0;
        vec_fifo_empty = vq.size() == 0 || vmask;
        mat_fifo_empty = mq.size() == 0;
    endtask

    task automatic push(input logic [15:0] m, input logic [15:0] v, input logic l);
        mq.push_back(m);
        vq.push_back(v);
        lq.push_back(l);
        upd();
    endtask

    task automatic flush;
        mq.delete();
        vq.delete();
        lq.delete();
        upd();
    endtask

    // one clock: sample outputs at the falling edge, pop the models after the rising edge
    task automatic cyc;
        @(negedge clk);
        rd      = vec_fifo_read;
        s_valid = res_valid;
        s_res   = res;
        s_row   = res_row;
        s_done  = done;
        chk("rd_match", 64'(mat_fifo_read), 64'(rd));
        chk("pop_gated", 64'(rd & (vec_fifo_empty | mat_fifo_empty)), 64'd0);
        @(posedge clk);
        #1;
        if (rd && mq.size() != 0 && vq.size() != 0) begin
            void'(mq.pop_front());
            void'(vq.pop_front());
            void'(lq.pop_front());
            pops++;
        end
        if (vtog) vmask = !vmask;
        upd();
    endtask

    task automatic go(input logic [9:0] n);
        num_rows = n;
        start    = 1'b1;
        pops     = 0;
        s_valid  = 1'b0;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40 && !s_valid; i++) cyc();
        chk(tag, 64'(s_valid), 64'd1);
    endtask

    initial begin
        upd();
        // reset held with data available and start asserted
        push(16'd5, 16'd5, 1'b1);
        start    = 1'b1;
        num_rows = 10'd1;
        repeat (3) begin
            cyc();
            chk("rst_valid", 64'(s_valid), 64'd0);
            chk("rst_done", 64'(s_done), 64'd0);
            chk("rst_read", 64'(rd), 64'd0);
            chk("rst_res", 64'(s_res), 64'd0);
            chk("rst_row", 64'(s_row), 64'd0);
        end
        start = 1'b0;
        rst   = 1'b1;
        repeat (2) cyc();
        chk("idle_no_pop", 64'(pops), 64'd0);
        flush();

        // single row: 2*5 + 3*6 + 4*7 = 56
        push(16'd2, 16'd5, 1'b0);
        push(16'd3, 16'd6, 1'b0);
        push(16'd4, 16'd7, 1'b1);
        go(10'd1);
        for (int i = 0; i < 10 && pops < 3; i++) cyc();
        chk("r1_pops", 64'(pops), 64'd3);
        cyc();
        chk("r1_lat_early", 64'(s_valid), 64'd0);
        cyc();
        chk("r1_valid", 64'(s_valid), 64'd1);
        chk("r1_res", 64'(s_res), 64'd56);
        chk("r1_row", 64'(s_row), 64'd0);
        chk("r1_done_early", 64'(s_done), 64'd0);
        cyc();
        chk("r1_done", 64'(s_done), 64'd1);
        chk("r1_valid_clr", 64'(s_valid), 64'd0);
        cyc();
        chk("r1_done_pulse", 64'(s_done), 64'd0);

        // two rows under backpressure; trailing entry must stay in the FIFO
        res_ready = 1'b0;
        push(16'd1, 16'd3, 1'b0);
        push(16'd2, 16'd4, 1'b1);
        push(16'd5, 16'd6, 1'b1);
        push(16'd7, 16'd1, 1'b1);
        go(10'd2);
        repeat (6) cyc();
        chk("bp_pops", 64'(pops), 64'd3);
        chk("bp_valid", 64'(s_valid), 64'd1);
        chk("bp_res", 64'(s_res), 64'd11);
        chk("bp_row", 64'(s_row), 64'd0);
        cyc();
        chk("bp_stable", 64'(s_res), 64'd11);
        res_ready = 1'b1;
        cyc();
        chk("bp_r0_res", 64'(s_res), 64'd11);
        chk("bp_r0_row", 64'(s_row), 64'd0);
        cyc();
        chk("bp_r1_valid", 64'(s_valid), 64'd1);
        chk("bp_r1_res", 64'(s_res), 64'd30);
        chk("bp_r1_row", 64'(s_row), 64'd1);
        cyc();
        chk("bp_done", 64'(s_done), 64'd1);
        chk("bp_left", 64'(mq.size()), 64'd1);
        chk("bp_pops_end", 64'(pops), 64'd3);
        flush();

        // zero-row block goes straight to DONE without popping
        push(16'd9, 16'd9, 1'b1);
        go(10'd0);
        cyc();
        chk("z_done", 64'(s_done), 64'd1);
        chk("z_pops", 64'(pops), 64'd0);
        cyc();
        chk("z_done_pulse", 64'(s_done), 64'd0);
        flush();

        // vector FIFO flickering empty every cycle: 1+2+3+4 = 10
        vtog = 1'b1;
        push(16'd1, 16'd1, 1'b0);
        push(16'd1, 16'd2, 1'b0);
        push(16'd1, 16'd3, 1'b0);
        push(16'd1, 16'd4, 1'b1);
        go(10'd1);
        wait_valid("tg_valid");
        chk("tg_res", 64'(s_res), 64'd10);
        chk("tg_row", 64'(s_row), 64'd0);
        chk("tg_pops", 64'(pops), 64'd4);
        cyc();
        chk("tg_done", 64'(s_done), 64'd1);
        vtog  = 1'b0;
        vmask = 1'b0;
        flush();

        // signed extremes and negative result sign extension
        push(16'h8000, 16'h8000, 1'b1);
        push(16'hFFFD, 16'd5, 1'b1);
        go(10'd2);
        wait_valid("sg_valid");
        chk("sg_r0_res", 64'(s_res), 64'd1073741824);
        chk("sg_r0_row", 64'(s_row), 64'd0);
        cyc();
        chk("sg_r1_res", 64'(s_res), 64'h00FF_FFFF_FFF1);
        chk("sg_r1_row", 64'(s_row), 64'd1);
        cyc();
        chk("sg_done", 64'(s_done), 64'd1);
        flush();

        // reset mid-row discards the partial sum
        push(16'd1, 16'd1, 1'b0);
        push(16'd2, 16'd1, 1'b0);
        push(16'd3, 16'd1, 1'b1);
        go(10'd1);
        for (int i = 0; i < 10 && pops < 2; i++) cyc();
        chk("mr_pops", 64'(pops), 64'd2);
        rst = 1'b0;
        #1;
        chk("mr_read", 64'(mat_fifo_read), 64'd0);
        chk("mr_valid", 64'(res_valid), 64'd0);
        chk("mr_done", 64'(done), 64'd0);
        flush();
        push(16'd1, 16'd9, 1'b1);
        #2;
        rst = 1'b1;
        go(10'd1);
        wait_valid("mr2_valid");
        chk("mr2_res", 64'(s_res), 64'd9);
        chk("mr2_row", 64'(s_row), 64'd0);
        chk("mr2_pops", 64'(pops), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
